vram_bus_responder: RTL

- Responder end of the DZCPU memory bus for the VRAM window 0x8000–0x9FFF.
- Holds an 8 KiB single-port byte RAM and serves CPU reads and writes with fixed 1-cycle latency.
- Also streams the whole window out over a valid/ready dump port, for bring-up and regression comparison against golden VRAM images.
- The CPU always has priority over the dump engine on the RAM port.

---
 rtl/vram_pkg.sv | 18 +
 rtl/vram_bus_responder_spram.sv | 35 +++
 rtl/vram_bus_responder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// vram_pkg
// Shared constants for the VRAM bus responder:
//   - default window base and (exclusive) window end in CPU address space
//   - open-bus value returned for reads outside the window
//   - dump engine state encoding
package vram_pkg;

    localparam logic [15:0] VRAM_BASE = 16'h8000;
    localparam logic [16:0] VRAM_END  = 17'h0A000;

    localparam logic [7:0]  OPEN_BUS  = 8'hFF;

    localparam logic [1:0]  DUMP_IDLE = 2'd0;
    localparam logic [1:0]  DUMP_RD   = 2'd1;
    localparam logic [1:0]  DUMP_PRES = 2'd2;
    localparam logic [1:0]  DUMP_DONE = 2'd3;

endpackage

// File: rtl/vram_bus_responder_spram.sv
// spram_sync
// Single-port synchronous RAM with a one-cycle registered read.
// When a write and a read hit the same cycle, oData returns the old contents.
// Ports:
//   iClock  rising-edge clock
//   iEn     port enable; oData only updates on enabled cycles
//   iWe     write enable (qualified by iEn)
//   iAddr   word index
//   iData   write data
//   oData   registered read data, held while iEn=0
module spram_sync #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8
)(
    input  logic                  iClock,
    input  logic                  iEn,
    input  logic                  iWe,
    input  logic [ADDR_WIDTH-1:0] iAddr,
    input  logic [DATA_WIDTH-1:0] iData,
    output logic [DATA_WIDTH-1:0] oData
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    // Read returns the pre-write contents so a same-cycle write is not forwarded.
    always_ff @(posedge iClock) begin
        if (iEn) begin
            if (iWe) begin
                mem[iAddr] <= iData;
            end
            oData <= mem[iAddr];
        end
    end

endmodule

// File: rtl/vram_bus_responder.sv
// vram_bus_responder
// Responder for the DZCPU VRAM window. Serves CPU reads/writes with a fixed
// one-cycle latency from a single-port RAM and can stream the whole window
// out over a valid/ready dump port. CPU strobes always win the RAM port; the
// dump engine stalls in its read state while the CPU is active.
// Ports:
//   iClock, iReset             clock, asynchronous active-low reset
//   iAddr, iData, iWe, iRe     CPU address, write data, write/read strobes
//   oHit                       iAddr falls inside the window (combinational)
//   oReady, oData              access complete / read data (cycle after strobe)
//   oWriteCount                saturating count of in-window writes
//   iDumpStart, iDumpReady     start pulse, consumer ready
//   oDumpValid, oDumpAddr,
//   oDumpData                  current dump beat
//   oDumpBusy, oDumpDone       dump in progress, pulse after the last beat
module vram_bus_responder
    import vram_pkg::*;
#(
    parameter logic [15:0] ADDR_BASE  = VRAM_BASE,
    parameter int          ADDR_WIDTH = 13,
    parameter int          DATA_WIDTH = 8
)(
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic [15:0]           iAddr,
    input  logic [DATA_WIDTH-1:0] iData,
    input  logic                  iWe,
    input  logic                  iRe,
    output logic                  oHit,
    output logic                  oReady,
    output logic [DATA_WIDTH-1:0] oData,
    output logic [15:0]           oWriteCount,
    input  logic                  iDumpStart,
    input  logic                  iDumpReady,
    output logic                  oDumpValid,
    output logic [15:0]           oDumpAddr,
    output logic [DATA_WIDTH-1:0] oDumpData,
    output logic                  oDumpBusy,
    output logic                  oDumpDone
);

    localparam logic [16:0]           WINDOW_END = {1'b0, ADDR_BASE} + (17'd1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = '1;

    logic                  cpuStrobe;
    logic                  cpuHit;
    logic                  cpuWrite;
    logic                  cpuReadHit;
    logic                  cpuReadMiss;
    logic [ADDR_WIDTH-1:0] cpuIndex;
    logic [ADDR_WIDTH-1:0] dumpPtr;
    logic [ADDR_WIDTH-1:0] ramAddr;
    logic                  ramEn;
    logic                  ramWe;
    logic [DATA_WIDTH-1:0] ramQ;
    logic [1:0]            dumpState;
    logic                  dumpIssue;
    logic                  dumpFresh;
    logic [DATA_WIDTH-1:0] dumpHold;
    logic                  readyQ;
    logic                  readHitQ;
    logic [DATA_WIDTH-1:0] dataHold;
    logic [15:0]           writeCount;

    assign cpuHit      = (iAddr >= ADDR_BASE) && ({1'b0, iAddr} < WINDOW_END);
    assign cpuIndex    = ADDR_WIDTH'(iAddr - ADDR_BASE);
    assign cpuStrobe   = iWe | iRe;
    assign cpuWrite    = iWe & cpuHit;
    // A combined write+read strobe behaves as a pure write.
    assign cpuReadHit  = iRe & ~iWe & cpuHit;
    assign cpuReadMiss = iRe & ~iWe & ~cpuHit;

    // Any CPU strobe, hit or miss, blocks the dump read for this cycle.
    assign dumpIssue   = (dumpState == DUMP_RD) && !cpuStrobe;
    assign ramEn       = (cpuStrobe & cpuHit) | dumpIssue;
    assign ramWe       = cpuWrite;
    assign ramAddr     = cpuStrobe ? cpuIndex : dumpPtr;

    spram_sync #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) uRam (
        .iClock (iClock),
        .iEn    (ramEn),
        .iWe    (ramWe),
        .iAddr  (ramAddr),
        .iData  (iData),
        .oData  (ramQ)
    );

    // CPU response path. A read hit shows the RAM output directly in the
    // ready cycle and is then copied into dataHold, so oData keeps the last
    // returned byte until another read replaces it.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            readyQ     <= 1'b0;
            readHitQ   <= 1'b0;
            dataHold   <= '0;
            writeCount <= '0;
        end else begin
            readyQ   <= cpuStrobe;
            readHitQ <= cpuReadHit;
            if (cpuReadMiss) begin
                dataHold <= DATA_WIDTH'(OPEN_BUS);
            end else if (readHitQ) begin
                dataHold <= ramQ;
            end
            if (cpuWrite && (writeCount != 16'hFFFF)) begin
                writeCount <= writeCount + 16'd1;
            end
        end
    end

    assign oHit        = cpuHit;
    assign oReady      = readyQ;
    assign oData       = readHitQ ? ramQ : dataHold;
    assign oWriteCount = writeCount;

    // Dump engine. The RAM output is only trustworthy in the first PRES cycle
    // (CPU traffic may reuse the port afterwards), so it is captured into
    // dumpHold at the end of that cycle to keep the beat stable while stalled.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            dumpState <= DUMP_IDLE;
            dumpPtr   <= '0;
            dumpFresh <= 1'b0;
            dumpHold  <= '0;
        end else begin
            dumpFresh <= 1'b0;
            if (dumpFresh) begin
                dumpHold <= ramQ;
            end
            case (dumpState)
                DUMP_IDLE: begin
                    if (iDumpStart) begin
                        dumpState <= DUMP_RD;
                        dumpPtr   <= '0;
                    end
                end
                DUMP_RD: begin
                    if (!cpuStrobe) begin
                        dumpState <= DUMP_PRES;
                        dumpFresh <= 1'b1;
                    end
                end
                DUMP_PRES: begin
                    if (iDumpReady) begin
                        if (dumpPtr == LAST_INDEX) begin
                            dumpState <= DUMP_DONE;
                        end else begin
                            dumpPtr   <= dumpPtr + ADDR_WIDTH'(1);
                            dumpState <= DUMP_RD;
                        end
                    end
                end
                DUMP_DONE: begin
                    dumpState <= DUMP_IDLE;
                end
                default: begin
                    dumpState <= DUMP_IDLE;
                end
            endcase
        end
    end

    assign oDumpValid = (dumpState == DUMP_PRES);
    assign oDumpAddr  = oDumpValid ? (ADDR_BASE + 16'(dumpPtr)) : 16'h0000;
    assign oDumpData  = oDumpValid ? (dumpFresh ? ramQ : dumpHold) : '0;
    assign oDumpBusy  = (dumpState == DUMP_RD) || (dumpState == DUMP_PRES);
    assign oDumpDone  = (dumpState == DUMP_DONE);

endmodule
